tscan_seq: RTL and testbench
============================

Name: tscan_seq

Overview:
- Scan sequencer on the prim_gclk domain, directly downstream of the test controller.
- Consumes tscan_enable, tscan_start, tscan_exe and raw tck. Produces tscan_end and texe_done back to the controller.
- Drives the core scan chains: shift enable, shift strobe, serial in, launch/capture pulses.
- Converts the slow tck-domain handshake into single-cycle prim_gclk strobes via synchronisers and edge detection.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for tck, tscan_enable, tscan_exe, tscan_start (min 2).
- LAUNCH_GAP, 4, prim_gclk cycles from launch pulse to capture pulse (1..255).
- DONE_HOLD, 3, minimum cycles texe_done stays high before it may fall (1..15).
- CNT_W, 16, width of shift_count.

Ports:
- prim_gclk  in  1  system clock; only clock of the block.
- prim_rst  in  1  synchronous, active-high reset.
- tck  in  1  raw test clock, asynchronous, used as data only.
- tscan_enable  in  1  scan mode request from controller (async).
- tscan_exe  in  1  execute request from controller (async).
- tscan_start  in  1  serial scan data from controller (async).
- scan_out  in  1  serial output of the core scan chain.
- tscan_end  out  1  registered scan_out returned to controller.
- texe_done  out  1  execute-complete level to controller.
- scan_se  out  1  scan shift enable to core flops.
- scan_shift  out  1  one-cycle shift strobe.
- scan_in  out  1  serial data into the core scan chain.
- scan_launch  out  1  one-cycle launch pulse.
- scan_capture  out  1  one-cycle capture pulse.
- shift_count  out  CNT_W  bits shifted since entering SHIFT; saturates at all-ones.

Behaviour:
- Reset: all outputs 0; all synchroniser flops 0; FSM in IDLE; internal counters 0.
- Sync/edge detect:
  - Every async input passes through SYNC_STAGES flops.
  - tck_rise is the synced tck high with its previous synced value low.
  - tscan_start is sampled from its synced value on tck_rise.
  - prim_gclk must be at least 4x tck; below that ratio behaviour is undefined.
- FSM states: IDLE, SHIFT, LAUNCH, WAIT, CAPTURE, DONE.
  - IDLE: if en_s, go to SHIFT and clear shift_count. Otherwise if exe_s, go to LAUNCH.
  - SHIFT: scan_se=1. On tck_rise:
    - scan_shift=1 for exactly 1 cycle.
    - scan_in is loaded with the synced tscan_start in the same cycle.
    - shift_count increments (saturating).
    - tscan_end is loaded with scan_out one cycle after the strobe.
  - SHIFT exit: if exe_s, go to LAUNCH (exe has priority over staying). If en_s and exe_s both fall, go to IDLE.
  - LAUNCH: scan_se=0; scan_launch=1 for one cycle; gap counter loaded with LAUNCH_GAP-1; go to WAIT.
  - WAIT: decrement the gap counter; at 0, go to CAPTURE.
  - CAPTURE: scan_capture=1 for one cycle; go to DONE.
  - DONE: texe_done=1. Stay until exe_s is 0 and the hold counter has reached DONE_HOLD. Then clear texe_done and return to SHIFT if en_s, else IDLE.
- Latency: synced input change to FSM reaction is SYNC_STAGES+1 cycles. Launch to capture is exactly LAUNCH_GAP cycles.
- exe_s falling during LAUNCH/WAIT/CAPTURE: the sequence completes anyway. DONE then exits after the hold time with no further handshake.
- tck_rise outside SHIFT is ignored; no strobe, no count.
- scan_shift, scan_launch and scan_capture are mutually exclusive in every cycle.
- prim_rst asserted in any state: next cycle all outputs are 0 and the FSM is in IDLE. Any partial shift or execute is abandoned.

Decomposition:
- Package tscan_pkg holds:
  - the FSM state encoding as a 3-bit localparam set;
  - the LAUNCH_GAP and DONE_HOLD range limits;
  - the minimum clock-ratio constant.
- One sub-module, tscan_sync: parameterised SYNC_STAGES-deep bit synchroniser with optional rising-edge output. It is instantiated four times: tck with edge, enable, exe, start.

Test Plan:
- Reset, then all inputs 0 for 20 cycles -> all outputs 0, shift_count=0, FSM IDLE.
- tscan_enable=1; tck at 1/8 prim_gclk; shift the 8 bits 1,0,1,1,0,0,1,0 -> 8 scan_shift pulses, scan_in matches each bit, shift_count=8, scan_se=1 throughout.
- After shifting, tscan_exe=1 with LAUNCH_GAP=4 -> scan_se falls, launch pulse, capture exactly 4 cycles later, then texe_done=1. Drop tscan_exe -> texe_done falls after ≥3 cycles and FSM returns to SHIFT (enable still 1).
- tscan_exe pulsed low 2 cycles after launch -> capture still occurs; texe_done pulses DONE_HOLD cycles then clears.
- prim_rst asserted mid-WAIT -> next cycle all outputs 0 and no capture pulse; FSM reaches IDLE.
- 70000 tck edges in SHIFT with CNT_W=16 -> shift_count saturates at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/tscan_pkg.sv
// Shared constants for the scan sequencer: FSM encoding, parameter limits, counter widths.
package tscan_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SHIFT   = 3'd1;
    localparam state_t ST_LAUNCH  = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_CAPTURE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    localparam int unsigned LAUNCH_GAP_MIN  = 1;
    localparam int unsigned LAUNCH_GAP_MAX  = 255;
    localparam int unsigned DONE_HOLD_MIN   = 1;
    localparam int unsigned DONE_HOLD_MAX   = 15;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned MIN_CLK_RATIO   = 4;

    localparam int unsigned GAP_W  = 8;
    localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/tscan_sync.sv
// Multi-flop bit synchroniser with an optional rising-edge strobe on the synced value.
module tscan_sync #(
    parameter int unsigned STAGES = 2,
    parameter bit          EDGE   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

    if (EDGE) begin : g_edge
        logic prev_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= sync_q[STAGES-1];
            end
        end

        assign rise_o = sync_q[STAGES-1] & ~prev_q;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
    end

endmodule

// File: rtl/tscan_seq.sv
// Scan sequencer: turns the slow tck-domain controller handshake into prim_gclk
// shift strobes and a launch/capture pair with a fixed cycle gap.
module tscan_seq
    import tscan_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LAUNCH_GAP  = 4,
    parameter int unsigned DONE_HOLD   = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             prim_gclk,
    input  logic             prim_rst,
    input  logic             tck,
    input  logic             tscan_enable,
    input  logic             tscan_exe,
    input  logic             tscan_start,
    input  logic             scan_out,
    output logic             tscan_end,
    output logic             texe_done,
    output logic             scan_se,
    output logic             scan_shift,
    output logic             scan_in,
    output logic             scan_launch,
    output logic             scan_capture,
    output logic [CNT_W-1:0] shift_count
);

    if (SYNC_STAGES < SYNC_STAGES_MIN ||
        LAUNCH_GAP < LAUNCH_GAP_MIN || LAUNCH_GAP > LAUNCH_GAP_MAX ||
        DONE_HOLD < DONE_HOLD_MIN || DONE_HOLD > DONE_HOLD_MAX) begin : g_bad_param
        $error("tscan_seq: parameter out of range");
    end

    // Bit 0 is tck (the only edge-detecting instance), then enable, exe, start.
    logic [3:0] async_v;
    logic [3:0] sync_v;
    logic [3:0] rise_v;

    assign async_v = {tscan_start, tscan_exe, tscan_enable, tck};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        tscan_sync #(
            .STAGES (SYNC_STAGES),
            .EDGE   (gi == 0)
        ) u_sync (
            .clk_i  (prim_gclk),
            .rst_i  (prim_rst),
            .d_i    (async_v[gi]),
            .q_o    (sync_v[gi]),
            .rise_o (rise_v[gi])
        );
    end

    logic en_s;
    logic exe_s;
    logic start_s;
    logic tck_rise;

    assign en_s     = sync_v[1];
    assign exe_s    = sync_v[2];
    assign start_s  = sync_v[3];
    // Non-edge instances tie their rise output low, so only tck contributes.
    assign tck_rise = (|rise_v) & sync_v[0];

    state_t            state_q;
    logic [GAP_W-1:0]  gap_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  count_q;
    logic              tscan_end_q;
    logic              texe_done_q;
    logic              scan_se_q;
    logic              scan_shift_q;
    logic              scan_in_q;
    logic              scan_launch_q;
    logic              scan_capture_q;

    // Pulse registers are set on entry to their state so they line up with it.
    always_ff @(posedge prim_gclk) begin
        if (prim_rst) begin
            state_q        <= ST_IDLE;
            gap_q          <= '0;
            hold_q         <= '0;
            count_q        <= '0;
            tscan_end_q    <= 1'b0;
            texe_done_q    <= 1'b0;
            scan_se_q      <= 1'b0;
            scan_shift_q   <= 1'b0;
            scan_in_q      <= 1'b0;
            scan_launch_q  <= 1'b0;
            scan_capture_q <= 1'b0;
        end else begin
            scan_shift_q   <= 1'b0;
            scan_launch_q  <= 1'b0;
            scan_capture_q <= 1'b0;
            if (scan_shift_q) begin
                tscan_end_q <= scan_out;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en_s) begin
                        state_q   <= ST_SHIFT;
                        scan_se_q <= 1'b1;
                        count_q   <= '0;
                    end else if (exe_s) begin
                        state_q       <= ST_LAUNCH;
                        scan_launch_q <= 1'b1;
                        gap_q         <= GAP_W'(LAUNCH_GAP - 1);
                    end
                end
                ST_SHIFT: begin
                    if (exe_s) begin
                        state_q       <= ST_LAUNCH;
                        scan_se_q     <= 1'b0;
                        scan_launch_q <= 1'b1;
                        gap_q         <= GAP_W'(LAUNCH_GAP - 1);
                    end else if (!en_s) begin
                        state_q   <= ST_IDLE;
                        scan_se_q <= 1'b0;
                    end else if (tck_rise) begin
                        scan_shift_q <= 1'b1;
                        scan_in_q    <= start_s;
                        if (count_q != '1) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (LAUNCH_GAP == 1) begin
                        state_q        <= ST_CAPTURE;
                        scan_capture_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Capture lands exactly LAUNCH_GAP cycles after the launch cycle.
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        state_q        <= ST_CAPTURE;
                        scan_capture_q <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state_q     <= ST_DONE;
                    texe_done_q <= 1'b1;
                    hold_q      <= '0;
                end
                ST_DONE: begin
                    if (hold_q != HOLD_W'(DONE_HOLD - 1)) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end else if (!exe_s) begin
                        texe_done_q <= 1'b0;
                        if (en_s) begin
                            state_q   <= ST_SHIFT;
                            scan_se_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tscan_end    = tscan_end_q;
    assign texe_done    = texe_done_q;
    assign scan_se      = scan_se_q;
    assign scan_shift   = scan_shift_q;
    assign scan_in      = scan_in_q;
    assign scan_launch  = scan_launch_q;
    assign scan_capture = scan_capture_q;
    assign shift_count  = count_q;

endmodule

// File: tb/tb_tscan_seq.sv
// Directed bench for tscan_seq: shift, launch/capture timing, done hold, reset abort, count saturation.
module tb_tscan_seq;
    import tscan_pkg::*;

    logic clk;
    logic prim_rst;
    logic tck;
    logic tscan_enable;
    logic tscan_exe;
    logic tscan_start;
    logic scan_out;

    logic        tscan_end, texe_done, scan_se, scan_shift, scan_in, scan_launch, scan_capture;
    logic [15:0] shift_count;
    logic        s_tscan_end, s_texe_done, s_scan_se, s_scan_shift, s_scan_in, s_scan_launch, s_scan_capture;
    logic [3:0]  s_shift_count;

    tscan_seq dut (
        .prim_gclk    (clk),
        .prim_rst     (prim_rst),
        .tck          (tck),
        .tscan_enable (tscan_enable),
        .tscan_exe    (tscan_exe),
        .tscan_start  (tscan_start),
        .scan_out     (scan_out),
        .tscan_end    (tscan_end),
        .texe_done    (texe_done),
        .scan_se      (scan_se),
        .scan_shift   (scan_shift),
        .scan_in      (scan_in),
        .scan_launch  (scan_launch),
        .scan_capture (scan_capture),
        .shift_count  (shift_count)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    tscan_seq #(.CNT_W(4)) dut_sat (
        .prim_gclk    (clk),
        .prim_rst     (prim_rst),
        .tck          (tck),
        .tscan_enable (tscan_enable),
        .tscan_exe    (tscan_exe),
        .tscan_start  (tscan_start),
        .scan_out     (scan_out),
        .tscan_end    (s_tscan_end),
        .texe_done    (s_texe_done),
        .scan_se      (s_scan_se),
        .scan_shift   (s_scan_shift),
        .scan_in      (s_scan_in),
        .scan_launch  (s_scan_launch),
        .scan_capture (s_scan_capture),
        .shift_count  (s_shift_count)
    );

    int checks   = 0;
    int failures = 0;

    int       cyc = 0;
    int       n_shift, n_launch, n_capture, excl_err, se_drops;
    int       launch_cyc, capture_cyc, done_rise_cyc, done_fall_cyc;
    logic [7:0] shift_log, end_log;
    logic     prev_shift = 1'b0;
    logic     prev_done  = 1'b0;
    logic     se_at_launch;
    logic     track_se   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (scan_shift) begin
            n_shift   = n_shift + 1;
            shift_log = {shift_log[6:0], scan_in};
        end
        if (prev_shift) end_log = {end_log[6:0], tscan_end};
        prev_shift = scan_shift;
        if (scan_launch) begin
            n_launch     = n_launch + 1;
            launch_cyc   = cyc;
            se_at_launch = scan_se;
        end
        if (scan_capture) begin
            n_capture   = n_capture + 1;
            capture_cyc = cyc;
        end
        if (texe_done && !prev_done) done_rise_cyc = cyc;
        if (!texe_done && prev_done) done_fall_cyc = cyc;
        prev_done = texe_done;
        if ((int'(scan_shift) + int'(scan_launch) + int'(scan_capture)) > 1) excl_err = excl_err + 1;
        if ((int'(s_scan_shift) + int'(s_scan_launch) + int'(s_scan_capture)) > 1) excl_err = excl_err + 1;
        if (track_se && !scan_se) se_drops = se_drops + 1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_mon();
        n_shift = 0; n_launch = 0; n_capture = 0; se_drops = 0;
        launch_cyc = 0; capture_cyc = 0; done_rise_cyc = 0; done_fall_cyc = 0;
        shift_log = '0; end_log = '0; se_at_launch = 1'b1;
    endtask

    task automatic test_reset();
        prim_rst = 1'b1; tck = 1'b0; tscan_enable = 1'b0; tscan_exe = 1'b0;
        tscan_start = 1'b0; scan_out = 1'b0;
        excl_err = 0;
        clear_mon();
        step(3);
        prim_rst = 1'b0;
        // tck toggles while idle; nothing may shift.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) tck = ~tck;
            @(negedge clk);
        end
        tck = 1'b0;
        checks++;
        if ({tscan_end, texe_done, scan_se, scan_shift, scan_in, scan_launch, scan_capture} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {tscan_end, texe_done, scan_se, scan_shift, scan_in, scan_launch, scan_capture});
        end
        checks++;
        if (shift_count !== 16'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", shift_count);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
        checks++;
        if (n_shift !== 0) begin
            failures++; $display("FAIL idle_tck_ignored got=%0d exp=0", n_shift);
        end
    endtask

    task automatic test_shift();
        logic [7:0] pat;
        pat = 8'b10110010;
        clear_mon();
        tscan_enable = 1'b1;
        step(6);
        track_se = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tck = 1'b0; tscan_start = pat[i]; scan_out = ~pat[i];
            step(4);
            tck = 1'b1;
            step(4);
        end
        tck = 1'b0;
        step(4);
        track_se = 1'b0;
        checks++;
        if (n_shift !== 8) begin
            failures++; $display("FAIL shift_pulses got=%0d exp=8", n_shift);
        end
        checks++;
        if (shift_log !== 8'hB2) begin
            failures++; $display("FAIL shift_scan_in got=%h exp=b2", shift_log);
        end
        checks++;
        if (end_log !== 8'h4D) begin
            failures++; $display("FAIL shift_tscan_end got=%h exp=4d", end_log);
        end
        checks++;
        if (shift_count !== 16'd8) begin
            failures++; $display("FAIL shift_count got=%0d exp=8", shift_count);
        end
        checks++;
        if (se_drops !== 0) begin
            failures++; $display("FAIL shift_se_held got=%0d low cycles exp=0", se_drops);
        end
    endtask

    task automatic test_execute();
        bit got;
        clear_mon();
        tscan_exe = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (texe_done) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            failures++; $display("FAIL exec_done_rise got=timeout exp=texe_done high");
        end
        checks++;
        if (se_at_launch !== 1'b0) begin
            failures++; $display("FAIL exec_se_at_launch got=%b exp=0", se_at_launch);
        end
        checks++;
        if (capture_cyc - launch_cyc !== 4) begin
            failures++; $display("FAIL exec_launch_gap got=%0d exp=4", capture_cyc - launch_cyc);
        end
        checks++;
        if (done_rise_cyc - capture_cyc !== 1) begin
            failures++; $display("FAIL exec_done_after_capture got=%0d exp=1", done_rise_cyc - capture_cyc);
        end
        step(6);
        tscan_exe = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!texe_done) got = 1'b1;
        end
        step(3);
        checks++;
        if (done_fall_cyc - done_rise_cyc !== 9) begin
            failures++; $display("FAIL exec_done_width got=%0d exp=9", done_fall_cyc - done_rise_cyc);
        end
        checks++;
        if (n_launch !== 1 || n_capture !== 1) begin
            failures++; $display("FAIL exec_pulse_count got=%0d/%0d exp=1/1", n_launch, n_capture);
        end
        checks++;
        if (dut.state_q !== ST_SHIFT || scan_se !== 1'b1) begin
            failures++; $display("FAIL exec_back_to_shift got=state %0d se %b exp=state %0d se 1",
                                 dut.state_q, scan_se, ST_SHIFT);
        end
    endtask

    task automatic test_exe_drop();
        bit got;
        clear_mon();
        tscan_exe = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (scan_launch) got = 1'b1;
        end
        step(2);
        tscan_exe = 1'b0;
        step(30);
        checks++;
        if (got !== 1'b1 || n_capture !== 1) begin
            failures++; $display("FAIL drop_capture got=launch %b captures %0d exp=launch 1 captures 1", got, n_capture);
        end
        checks++;
        if (capture_cyc - launch_cyc !== 4) begin
            failures++; $display("FAIL drop_launch_gap got=%0d exp=4", capture_cyc - launch_cyc);
        end
        checks++;
        if (done_fall_cyc - done_rise_cyc !== 3) begin
            failures++; $display("FAIL drop_done_hold got=%0d exp=3", done_fall_cyc - done_rise_cyc);
        end
        checks++;
        if (dut.state_q !== ST_SHIFT) begin
            failures++; $display("FAIL drop_return_state got=%0d exp=%0d", dut.state_q, ST_SHIFT);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        clear_mon();
        tscan_exe = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (scan_launch) got = 1'b1;
        end
        step(1);
        prim_rst = 1'b1;
        step(1);
        checks++;
        if ({tscan_end, texe_done, scan_se, scan_shift, scan_in, scan_launch, scan_capture} !== 7'b0 ||
            shift_count !== 16'd0 || got !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_outputs got=%b count %0d launch %b exp=0000000 count 0 launch 1",
                     {tscan_end, texe_done, scan_se, scan_shift, scan_in, scan_launch, scan_capture},
                     shift_count, got);
        end
        tscan_exe = 1'b0; tscan_enable = 1'b0;
        step(2);
        prim_rst = 1'b0;
        step(10);
        checks++;
        if (n_capture !== 0) begin
            failures++; $display("FAIL rst_wait_no_capture got=%0d exp=0", n_capture);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++; $display("FAIL rst_wait_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_saturation();
        clear_mon();
        tscan_enable = 1'b1; tscan_start = 1'b1; scan_out = 1'b1;
        step(6);
        for (int i = 0; i < 15; i++) begin
            tck = 1'b1; step(2);
            tck = 1'b0; step(2);
        end
        step(4);
        checks++;
        if (s_shift_count !== 4'd15 || shift_count !== 16'd15) begin
            failures++; $display("FAIL sat_reach got=%0d/%0d exp=15/15", s_shift_count, shift_count);
        end
        for (int i = 0; i < 5; i++) begin
            tck = 1'b1; step(2);
            tck = 1'b0; step(2);
        end
        step(4);
        checks++;
        if (s_shift_count !== 4'd15) begin
            failures++; $display("FAIL sat_no_wrap got=%0d exp=15", s_shift_count);
        end
        checks++;
        if (shift_count !== 16'd20) begin
            failures++; $display("FAIL sat_wide_count got=%0d exp=20", shift_count);
        end
        checks++;
        if ({s_scan_se, s_scan_in, s_tscan_end, s_texe_done} !== 4'b1110) begin
            failures++; $display("FAIL sat_outputs got=%b exp=1110", {s_scan_se, s_scan_in, s_tscan_end, s_texe_done});
        end
        checks++;
        if (excl_err !== 0) begin
            failures++; $display("FAIL pulse_exclusive got=%0d overlaps exp=0", excl_err);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_execute();
        test_exe_drop();
        test_reset_mid_wait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
